// File: rtl/decoder_pkg.sv
// decoder_pkg: shared enums and opcode constants for the decode stage
package decoder_pkg;
  typedef enum logic {decoder_next, decoder_keep} decode_state_t;
  typedef enum logic {font_reg, font_imm} alu_s1_font_t;
  typedef enum logic [2:0] {op_none, op_move, op_add, op_sub, op_and, op_or, op_xor} alu_opcode_t;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOVR = 4'd1;
  localparam logic [3:0] OP_MOVI = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
endpackage

// File: rtl/decode_skid.sv
// decode_skid: two-entry (main + skid) valid/ready buffer with flush
module decode_skid
  import decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output decode_state_t state
);
  logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         acc, main_free;
  always_comb begin
    acc          = in_valid & ~skid_valid_q;
    main_free    = ~main_valid_q | out_ready;
    main_valid_d = ~flush & (main_free ? (skid_valid_q | acc) : 1'b1);
    main_d       = (main_free & ~flush) ? (skid_valid_q ? skid_q : (acc ? in_data : main_q)) : main_q;
    skid_valid_d = ~flush & ~main_free & (skid_valid_q | acc);
    skid_d       = (~main_free & acc) ? in_data : skid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;
  assign state     = skid_valid_q ? decoder_keep : decoder_next;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: cracks raw instructions into a decoded bundle behind a
// two-entry skid buffer, with saturating handshake counters.
module decode_stage
  import decoder_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int REG_NUM    = 16,
  parameter int IMM_W      = 16,
  parameter int DATA_W     = 32,
  parameter bit IMM_SIGNED = 1'b1,
  parameter int CNT_W      = 32,
  localparam int REG_BITS  = $clog2(REG_NUM),
  localparam int DEC_W     = 6 + 3 * REG_BITS + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEC_W-1:0]   out_dec,
  output logic [CNT_W-1:0]   cnt_decoded,
  output logic [CNT_W-1:0]   cnt_illegal,
  output decode_state_t      dbg_state
);
  typedef struct packed {
    alu_s1_font_t          alu_s1_font;
    alu_opcode_t           alu_opcode;
    logic                  wb_wr;
    logic [REG_BITS-1:0]   reg_s1;
    logic [REG_BITS-1:0]   reg_s2;
    logic [REG_BITS-1:0]   reg_dst;
    logic [DATA_W-1:0]     imm;
    logic                  illegal;
  } dec_t;

  if (4 + 3 * REG_BITS + IMM_W > INSTR_W) begin : g_bad_enc
    $error("decode_stage: op/reg/imm fields do not fit in INSTR_W");
  end

  // Ones above the immediate field; zero when DATA_W == IMM_W.
  localparam logic [DATA_W-1:0] HI_MASK = ~((DATA_W'(1) << IMM_W) - DATA_W'(1));

  logic [3:0]       op;
  dec_t             dec, out_bundle;
  logic             hs;
  logic [CNT_W-1:0] cnt_decoded_q, cnt_decoded_d, cnt_illegal_q, cnt_illegal_d;

  always_comb begin
    op              = in_instr[INSTR_W-1 -: 4];
    dec.reg_dst     = in_instr[INSTR_W-5 -: REG_BITS];
    dec.reg_s1      = in_instr[INSTR_W-5-REG_BITS -: REG_BITS];
    dec.reg_s2      = in_instr[INSTR_W-5-2*REG_BITS -: REG_BITS];
    dec.imm         = DATA_W'(in_instr[IMM_W-1:0]) | ((IMM_SIGNED && in_instr[IMM_W-1]) ? HI_MASK : '0);
    dec.illegal     = op > OP_XOR;
    dec.wb_wr       = ~dec.illegal & (op != OP_NOP);
    dec.alu_s1_font = (op == OP_MOVI || op == OP_ADDI) ? font_imm : font_reg;
    dec.alu_opcode  = (op == OP_MOVR || op == OP_MOVI) ? op_move :
                      (op == OP_ADD  || op == OP_ADDI) ? op_add  :
                      (op == OP_SUB) ? op_sub :
                      (op == OP_AND) ? op_and :
                      (op == OP_OR)  ? op_or  :
                      (op == OP_XOR) ? op_xor : op_none;
  end

  decode_skid #(.W(DEC_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_bundle),
    .state    (dbg_state)
  );

  assign out_dec = out_bundle;

  // Handshakes during a flush cycle still count: the beat really left.
  always_comb begin
    hs            = out_valid & out_ready;
    cnt_decoded_d = (hs && cnt_decoded_q != '1) ? cnt_decoded_q + CNT_W'(1) : cnt_decoded_q;
    cnt_illegal_d = (hs && out_bundle.illegal && cnt_illegal_q != '1) ? cnt_illegal_q + CNT_W'(1) : cnt_illegal_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_decoded_q <= '0;
      cnt_illegal_q <= '0;
    end else begin
      cnt_decoded_q <= cnt_decoded_d;
      cnt_illegal_q <= cnt_illegal_d;
    end
  end

  assign cnt_decoded = cnt_decoded_q;
  assign cnt_illegal = cnt_illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized scoreboard bench plus directed literal checks;
// a second instance covers zero-extension and narrow saturating counters.
module tb_decode_stage;
  import decoder_pkg::*;
  localparam int DW = 50;

  logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]   in_instr = '0;
  logic          in_ready, out_valid, in_ready_u, out_valid_u;
  logic [DW-1:0] out_dec, out_dec_u;
  logic [31:0]   cnt_dec, cnt_ill;
  logic [2:0]    cnt_dec_u, cnt_ill_u;
  decode_state_t st, st_u;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_dec(out_dec),
    .cnt_decoded(cnt_dec), .cnt_illegal(cnt_ill), .dbg_state(st)
  );

  decode_stage #(.IMM_SIGNED(1'b0), .CNT_W(3)) dut_u (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_instr(in_instr), .out_valid(out_valid_u), .out_ready(out_ready), .out_dec(out_dec_u),
    .cnt_decoded(cnt_dec_u), .cnt_illegal(cnt_ill_u), .dbg_state(st_u)
  );

  int          checks = 0, errors = 0, n_acc = 0;
  bit          run = 1'b0;
  logic [31:0] q[$];
  longint      m_dec = 0, m_ill = 0;
  int          alu_tab[9] = '{0, 1, 1, 2, 2, 3, 4, 5, 6};

  // Bundle order: font, alu op, wb, s1, s2, dst, imm, illegal.
  function automatic logic [DW-1:0] model_dec(logic [31:0] i, bit sgn);
    int          op = int'(i[31:28]);
    bit          ill = op > 8;
    logic [31:0] imm = (sgn && i[15]) ? {16'hFFFF, i[15:0]} : {16'h0000, i[15:0]};
    logic [2:0]  alu = ill ? 3'd0 : 3'(alu_tab[op]);
    bit          fimm = (op == 2 || op == 4);
    bit          wb = !ill && op != 0;
    return {fimm, alu, wb, i[23:20], i[19:16], i[27:24], imm, ill};
  endfunction

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, got, exp, $time);
    end
  endtask

  // Reference: an in-order queue of at most two accepted instructions.
  initial forever begin
    bit ir;
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_dec = 0;
      m_ill = 0;
    end else begin
      ir = q.size() < 2;
      if (q.size() > 0 && out_ready) begin
        m_dec++;
        if (q[0][31:28] > 4'd8) m_ill++;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && ir) begin
        q.push_back(in_instr);
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("in_ready_u", in_ready_u, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      chk("out_valid_u", out_valid_u, q.size() > 0);
      chk("state_keep", st == decoder_keep, q.size() == 2);
      if (q.size() > 0) begin
        chk("out_dec", out_dec, model_dec(q[0], 1'b1));
        chk("out_dec_u", out_dec_u, model_dec(q[0], 1'b0));
      end
      chk("cnt_decoded", cnt_dec, m_dec);
      chk("cnt_illegal", cnt_ill, m_ill);
      chk("cnt_decoded_u", cnt_dec_u, m_dec > 7 ? 7 : m_dec);
      chk("cnt_illegal_u", cnt_ill_u, m_ill > 7 ? 7 : m_ill);
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] got[$];
    int         start, cyc;
    bit         acc;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_dec", out_dec, 0);
    chk("rst_cnt", {cnt_dec, cnt_ill}, 0);
    rst = 1'b0;
    run = 1'b1;

    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h3312_0000;
    @(negedge clk);
    in_instr = 32'h4500_FFF0;
    chk("add_valid", out_valid, 1);
    chk("add_dec", out_dec, {1'b0, 3'd2, 1'b1, 4'd1, 4'd2, 4'd3, 32'h0, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    chk("addi_sext", out_dec, {1'b1, 3'd2, 1'b1, 4'd0, 4'd0, 4'd5, 32'hFFFF_FFF0, 1'b0});
    chk("addi_zext", out_dec_u, {1'b1, 3'd2, 1'b1, 4'd0, 4'd0, 4'd5, 32'h0000_FFF0, 1'b0});
    @(negedge clk);

    pulse_reset();
    in_valid = 1'b1; in_instr = 32'hC123_4567;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_dec", out_dec, {1'b0, 3'd0, 1'b0, 4'd2, 4'd3, 4'd1, 32'h0000_4567, 1'b1});
    @(negedge clk);
    chk("ill_cnt", {cnt_dec, cnt_ill}, {32'd1, 32'd1});

    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h3100_0000;
    @(negedge clk);
    in_instr = 32'h3200_0000;
    @(negedge clk);
    in_instr = 32'h3300_0000;
    chk("stall_in_ready", in_ready, 0);
    @(negedge clk);
    chk("stall_held", {in_ready, out_dec[36:33]}, {1'b0, 4'd1});
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) got.push_back(out_dec[36:33]);
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    chk("order_cnt", got.size(), 3);
    if (got.size() == 3) chk("order", {got[0], got[1], got[2]}, {4'd1, 4'd2, 4'd3});

    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h3400_0000;
    repeat (2) @(negedge clk);
    chk("pre_flush_full", in_ready, 0);
    flush = 1'b1; in_instr = 32'h3F00_0000;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_empty", {out_valid, in_ready}, 2'b01);
    repeat (3) @(negedge clk);
    chk("flush_dropped", out_valid, 0);

    start = n_acc;
    cyc = 0;
    while (n_acc - start < 10000 && cyc < 60000) begin
      in_valid  = $urandom_range(0, 99) < 75;
      out_ready = $urandom_range(0, 99) < 65;
      flush     = $urandom_range(0, 299) == 0;
      in_instr  = $urandom;
      @(negedge clk);
      cyc++;
    end
    flush = 1'b0; in_valid = 1'b0;
    chk("random_done", n_acc - start >= 10000, 1);
    chk("sat_u", {cnt_dec_u, cnt_ill_u}, {3'd7, 3'd7});

    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h1500_0000;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out", {out_valid, in_ready, out_valid_u, in_ready_u}, 4'b0101);
    chk("arst_dec", out_dec, 0);
    chk("arst_cnt", {cnt_dec, cnt_ill, cnt_dec_u, cnt_ill_u}, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h2700_0042;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_accept", {out_valid, out_dec[36:33]}, {1'b1, 4'd7});
    repeat (2) @(negedge clk);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
